regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file: NRD combinational read ports, NWR write ports.
//  Write-to-read bypass on every read port; per-register pending (scoreboard) bits for ID hazard checks.
//  Post-reset clear sequencer zeroes the array, so there is no single-cycle array reset.
//  Sits between ID (reads, pending set) and WB (writes, pending clear).
// PARAMETERS
//  XLEN  32  data width
//  NREG  32  register count; register 0 reads as zero and is never written
//  AW    5   address width, = clog2(NREG)
//  NRD   2   read port count
//  NWR   2   write port count; higher index has priority
// PORTS
//  clk        in   1         clock
//  rst        in   1         sync reset, active-high
//  we         in   NWR       write enable, one bit per port
//  waddr      in   NWR*AW    write address; port k at [k*AW +: AW]
//  wdata      in   NWR*XLEN  write data; port k at [k*XLEN +: XLEN]
//  re         in   NRD       read enable, one bit per port
//  raddr      in   NRD*AW    read address, packed like waddr
//  rdata      out  NRD*XLEN  read data, combinational
//  pend_o     out  NRD       read register has an outstanding write
//  pset       in   1         mark register pset_addr pending (ID issue)
//  pset_addr  in   AW        destination being issued
//  ready      out  1         clear sweep done; block accepts traffic
// BEHAVIOUR
//  States: CLEAR and RUN.
//  - rst=1: state<=CLEAR, clr_idx<=0, ready<=0.
//  - CLEAR, each cycle: regs[clr_idx]<=0, pend[clr_idx]<=0, clr_idx++.
//  - CLEAR -> RUN on the edge after clr_idx==NREG-1.
//  - ready=1 exactly NREG cycles after the first cycle with rst=0.
//  In CLEAR and while rst=1:
//  - we and pset are ignored.
//  - rdata=0 and pend_o=0 on all ports.
//  rst asserted mid-operation (any state): the sweep restarts from index 0.
//  RUN writes, at posedge:
//  - Port k writes when we[k]=1 and waddr_k!=0.
//  - Same address on several ports: the highest k wins.
//  - Same write latency for every port: 1 edge.
//  RUN read port j, combinational, in priority order:
//  - re[j]=0 or raddr_j==0: rdata_j=0.
//  - Else if any active write port k has waddr_k==raddr_j: rdata_j=wdata_k, highest such k.
//  - Else rdata_j=regs[raddr_j].
//  Pending bits (RUN only):
//  - An active write to addr a clears pend[a] at the edge.
//  - pset=1 with pset_addr!=0 sets pend[pset_addr].
//  - Set and clear of the same addr in the same cycle: set wins, since the new issue overrides.
//  - pend[0] is always 0.
//  - pend_o[j] = re[j] & raddr_j!=0 & pend[raddr_j] & ~(any active write to raddr_j this cycle).
//    A bypassed value is never reported pending.
//  No X on any output after reset; NREG is not required to be a power of two (AW covers it).
// TESTING
//  1. rst 1 cycle, then idle, NREG=32 -> ready low for 32 cycles, high on the 33rd; all reads return 0.
//  2. we0=1, waddr0=5, wdata0=0xDEADBEEF; same cycle raddr0=5, re0=1 -> rdata0=0xDEADBEEF (bypass).
//     Next cycle, with no write active -> rdata0=0xDEADBEEF (from array).
//  3. we0=we1=1, both addr 7, wdata 0x11/0x22 -> bypass and later read both give 0x22.
//     Write to addr 0 -> reads of x0 stay 0.
//  4. pset addr 9 -> pend_o=1 for reads of 9.
//     WB write to 9 -> pend_o=0 in that cycle; pend clear afterwards.
//     pset 9 and write 9 in the same cycle -> pend[9] stays 1.
//  5. rst pulsed at sweep index 10, and again in RUN with regs populated -> ready drops.
//     Sweep restarts: 32 cycles to ready, all regs 0, all pend 0.
//  6. Writes and pset during CLEAR -> no effect; after ready, reg reads 0 and pend_o=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and scoreboard bits.
// A post-reset sweep zeroes the array one entry per cycle before traffic is accepted.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      pend_o,
    input  logic                pset,
    input  logic [AW-1:0]       pset_addr,
    output logic                ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic            run;
    logic [NWR-1:0]  wact;

    assign run = ready & ~rst;

    always_comb begin
        wact = '0;
        for (int k = 0; k < NWR; k++) begin
            wact[k] = run & we[k] & (waddr[k*AW +: AW] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
            pend[clr_idx] <= 1'b0;
            clr_idx       <= clr_idx + 1'b1;
            if (clr_idx == AW'(NREG - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            // later ports overwrite earlier ones on an address collision
            for (int k = 0; k < NWR; k++) begin
                if (wact[k]) begin
                    regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
                    pend[waddr[k*AW +: AW]] <= 1'b0;
                end
            end
            if (pset && pset_addr != '0) begin
                pend[pset_addr] <= 1'b1;
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] byp;

        assign ra = raddr[j*AW +: AW];

        always_comb begin
            hit = 1'b0;
            byp = regs[ra];
            for (int k = 0; k < NWR; k++) begin
                if (wact[k] && waddr[k*AW +: AW] == ra) begin
                    hit = 1'b1;
                    byp = wdata[k*XLEN +: XLEN];
                end
            end
        end

        assign rdata[j*XLEN +: XLEN] = (run & re[j] & (ra != '0)) ? byp : '0;
        // a value being bypassed this cycle is already available
        assign pend_o[j] = run & re[j] & (ra != '0) & pend[ra] & ~hit;
    end

endmodule
